// File: rtl/tree_mgt_pkg.sv
// Shared types and helpers for the tree space manager front-end.
package tree_mgt_pkg;

  localparam int TOKEN_WIDTH_DEF = 8;

  // The round-robin search works on a fixed-width request vector so that one
  // function can serve any client count up to MAX_CLIENT.
  localparam int MAX_CLIENT   = 32;
  localparam int CLIENT_IDX_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GRANT = 2'd2
  } alloc_state_e;

  // Returns the first requester at or after ptr, wrapping at nb-1 -> 0.
  // The result is meaningless when req is all zero; callers gate on |req.
  function automatic logic [CLIENT_IDX_W-1:0] rr_pick(
    input logic [MAX_CLIENT-1:0]   req,
    input logic [CLIENT_IDX_W-1:0] nb,
    input logic [CLIENT_IDX_W-1:0] ptr
  );
    logic [CLIENT_IDX_W-1:0] idx;
    logic                    found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < MAX_CLIENT; i++) begin
      idx = ptr + i[CLIENT_IDX_W-1:0];
      if (idx >= nb) idx = idx - nb;
      if (!found && (i < int'(nb)) && req[idx[4:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/tree_mgt_free_fifo.sv
// Synchronous FIFO buffering freed tokens on their way to the space manager.
module tree_mgt_free_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage write; no reset so it maps onto plain registers or a small RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tree_mgt_client_arbiter.sv
// Merges per-engine token allocate/free traffic onto the manager's single
// request and free channels. Allocation is serialised by a small FSM; frees
// are arbitrated straight into a FIFO that drains to the manager.
// Supports up to 32 clients.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for any alloc request while the manager is not full
//   ST_REQ   | mgr_req_valid high, waiting for the manager to hand a token
//   ST_GRANT | one-cycle grant pulse to the latched winner with the token
module tree_mgt_client_arbiter
  import tree_mgt_pkg::*;
#(
  parameter int TOKEN_WIDTH = TOKEN_WIDTH_DEF,
  parameter int NB_CLIENT   = 2,
  parameter int FREE_DEPTH  = 4
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NB_CLIENT-1:0]             cl_alloc_valid,
  output logic [NB_CLIENT-1:0]             cl_alloc_ready,
  output logic [TOKEN_WIDTH-1:0]           cl_alloc_addr,
  input  logic [NB_CLIENT-1:0]             cl_free_valid,
  output logic [NB_CLIENT-1:0]             cl_free_ready,
  input  logic [NB_CLIENT*TOKEN_WIDTH-1:0] cl_free_addr,
  output logic                             tree_full,
  output logic                             mgr_req_valid,
  input  logic                             mgr_req_ready,
  input  logic [TOKEN_WIDTH-1:0]           mgr_req_addr,
  output logic                             mgr_free_valid,
  input  logic                             mgr_free_ready,
  output logic [TOKEN_WIDTH-1:0]           mgr_free_addr,
  input  logic                             mgr_full
);

  localparam int PW = (NB_CLIENT > 1) ? $clog2(NB_CLIENT) : 1;

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] idx);
    rr_next = (idx == PW'(NB_CLIENT - 1)) ? '0 : idx + PW'(1);
  endfunction

  alloc_state_e           state_q, state_d;
  logic [PW-1:0]          winner_q, winner_d;
  logic [PW-1:0]          alloc_ptr_q, alloc_ptr_d;
  logic [TOKEN_WIDTH-1:0] addr_q, addr_d;
  logic [PW-1:0]          alloc_win;

  logic [PW-1:0]          free_ptr_q, free_ptr_d;
  logic [PW-1:0]          free_win;
  logic                   free_full, free_empty, free_push, free_pop;
  logic [TOKEN_WIDTH-1:0] free_data;

  assign tree_full     = mgr_full;
  assign cl_alloc_addr = addr_q;

  assign alloc_win = PW'(rr_pick(MAX_CLIENT'(cl_alloc_valid),
                                 CLIENT_IDX_W'(NB_CLIENT),
                                 CLIENT_IDX_W'(alloc_ptr_q)));

  // Alloc FSM next-state and outputs.
  always_comb begin
    state_d        = state_q;
    winner_d       = winner_q;
    alloc_ptr_d    = alloc_ptr_q;
    addr_d         = addr_q;
    mgr_req_valid  = 1'b0;
    cl_alloc_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (|cl_alloc_valid && !mgr_full) begin
          winner_d = alloc_win;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        mgr_req_valid = 1'b1;
        if (mgr_req_ready) begin
          addr_d  = mgr_req_addr;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        cl_alloc_ready[winner_q] = 1'b1;
        alloc_ptr_d              = rr_next(winner_q);
        state_d                  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Free-path arbitration: ready only from the registered FIFO occupancy, so
  // a pop in the same cycle never opens a slot for a push.
  assign free_win  = PW'(rr_pick(MAX_CLIENT'(cl_free_valid),
                                 CLIENT_IDX_W'(NB_CLIENT),
                                 CLIENT_IDX_W'(free_ptr_q)));
  assign free_push = aresetn & (|cl_free_valid) & ~free_full;
  assign free_data = cl_free_addr[free_win*TOKEN_WIDTH +: TOKEN_WIDTH];
  assign free_ptr_d = free_push ? rr_next(free_win) : free_ptr_q;

  // One-hot accept towards the winning free client.
  always_comb begin
    cl_free_ready = '0;
    if (free_push) cl_free_ready[free_win] = 1'b1;
  end

  assign mgr_free_valid = ~free_empty;
  assign free_pop       = ~free_empty & mgr_free_ready;

  // State register for the alloc FSM and both round-robin pointers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      winner_q    <= '0;
      alloc_ptr_q <= '0;
      addr_q      <= '0;
      free_ptr_q  <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      alloc_ptr_q <= alloc_ptr_d;
      addr_q      <= addr_d;
      free_ptr_q  <= free_ptr_d;
    end
  end

  tree_mgt_free_fifo #(
    .W     (TOKEN_WIDTH),
    .DEPTH (FREE_DEPTH)
  ) u_free_fifo (
    .clk_i       (aclk),
    .rst_n_i     (aresetn),
    .push_i      (free_push),
    .push_data_i (free_data),
    .pop_i       (free_pop),
    .head_o      (mgr_free_addr),
    .full_o      (free_full),
    .empty_o     (free_empty)
  );

endmodule
